// File: rtl/slot_reel_engine.sv
// ---------------------------------------------------------------------------
// slot_reel_engine
//
// Produces the three column symbols for the downstream slot-machine game FSM.
// The three reels are modulo-NUM_SYM counters. Each one starts at a
// pseudo-random position taken from a free-running 16-bit LFSR and advances
// once per tick. A stop request, or an auto-stop after MAX_SPIN cycles,
// freezes the reels one at a time, STOP_GAP cycles apart. The block then holds
// the final symbols and raises result_valid.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   spin          lever level; starts a spin from IDLE or DONE
//   stop          stop request level; only acted on while spinning
//   reel0..reel2  column symbols, always in 0..NUM_SYM-1
//   moving        bit i set while reel i is advancing
//   done          one-cycle pulse when the last reel freezes
//   result_valid  high while the final result is being held (DONE)
// ---------------------------------------------------------------------------
module slot_reel_engine #(
    parameter int          SYM_W     = 3,
    parameter int          NUM_SYM   = 6,
    parameter int          STEP_DIV  = 2_000_000,
    parameter int          STOP_GAP  = 12_000_000,
    parameter int          MAX_SPIN  = 100_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spin,
    input  logic             stop,
    output logic [SYM_W-1:0] reel0,
    output logic [SYM_W-1:0] reel1,
    output logic [SYM_W-1:0] reel2,
    output logic [2:0]       moving,
    output logic             done,
    output logic             result_valid
);

    localparam int TICK_W = $clog2(STEP_DIV);
    localparam int GAP_W  = $clog2(STOP_GAP + 1);
    localparam int SPIN_W = $clog2(MAX_SPIN + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STOP_GAP - 1);
    localparam logic [SPIN_W-1:0] SPIN_LAST = SPIN_W'(MAX_SPIN - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(NUM_SYM - 1);
    localparam logic [SYM_W:0]    SYM_COUNT = (SYM_W + 1)'(NUM_SYM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN  = 3'd1,
        STOP1 = 3'd2,
        STOP2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [15:0]         lfsr_reg, lfsr_next;
    logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [SPIN_W-1:0]   spin_cnt_reg, spin_cnt_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [SYM_W-1:0]    reel_reg [3];
    logic [SYM_W-1:0]    reel_next [3];
    logic [2:0]          moving_reg, moving_next;
    logic                done_reg, done_next;
    logic                tick;
    logic [SYM_W-1:0]    load_val [3];

    // Start positions: a SYM_W-bit slice of the LFSR per reel. Because
    // NUM_SYM > 2^(SYM_W-1), one conditional subtraction folds any raw slice
    // into 0..NUM_SYM-1.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_load
            logic [SYM_W-1:0] raw;
            assign raw          = lfsr_reg[3*gi +: SYM_W];
            assign load_val[gi] = ({1'b0, raw} >= SYM_COUNT)
                                  ? raw - SYM_COUNT[SYM_W-1:0] : raw;
        end
    endgenerate

    assign tick = (moving_reg != 3'b000) && (tick_cnt_reg == TICK_LAST);

    always_comb begin
        state_next    = state_reg;
        lfsr_next     = {lfsr_reg[14:0],
                         lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        spin_cnt_next = spin_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        moving_next   = moving_reg;
        done_next     = 1'b0;

        // The tick counter only runs while some reel is moving.
        if (moving_reg == 3'b000 || tick) begin
            tick_cnt_next = '0;
        end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
        end

        // Advancement uses the pre-edge moving bit, so a reel that freezes on
        // a tick edge still takes that final step.
        for (int i = 0; i < 3; i++) begin
            reel_next[i] = reel_reg[i];
            if (tick && moving_reg[i]) begin
                reel_next[i] = (reel_reg[i] == SYM_LAST) ? '0
                                                         : reel_reg[i] + SYM_W'(1);
            end
        end

        case (state_reg)
            IDLE, DONE: begin
                if (spin) begin
                    state_next    = SPIN;
                    moving_next   = 3'b111;
                    spin_cnt_next = '0;
                    tick_cnt_next = '0;
                    for (int i = 0; i < 3; i++) begin
                        reel_next[i] = load_val[i];
                    end
                end
            end
            SPIN: begin
                spin_cnt_next = spin_cnt_reg + SPIN_W'(1);
                if (stop || spin_cnt_reg == SPIN_LAST) begin
                    state_next     = STOP1;
                    moving_next[0] = 1'b0;
                    gap_cnt_next   = '0;
                end
            end
            STOP1: begin
                gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next     = STOP2;
                    moving_next[1] = 1'b0;
                    gap_cnt_next   = '0;
                end
            end
            STOP2: begin
                gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next     = DONE;
                    moving_next[2] = 1'b0;
                    done_next      = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            lfsr_reg     <= LFSR_SEED;
            tick_cnt_reg <= '0;
            spin_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            moving_reg   <= 3'b000;
            done_reg     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                reel_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            lfsr_reg     <= lfsr_next;
            tick_cnt_reg <= tick_cnt_next;
            spin_cnt_reg <= spin_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            moving_reg   <= moving_next;
            done_reg     <= done_next;
            for (int i = 0; i < 3; i++) begin
                reel_reg[i] <= reel_next[i];
            end
        end
    end

    assign reel0        = reel_reg[0];
    assign reel1        = reel_reg[1];
    assign reel2        = reel_reg[2];
    assign moving       = moving_reg;
    assign done         = done_reg;
    assign result_valid = (state_reg == DONE);

endmodule
